// File: rtl/fifo_ahb_master_pkg.sv
// Shared AHB-Lite encodings, FIFO entry layout and FSM state type for fifo_ahb_master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fifo_ahb_master_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEF     = 4'b0011;

    localparam int ENTRY_W = 36;

    // Entry kind codes held in the top two bits of a FIFO entry
    typedef enum logic [1:0] {
        KIND_RSVD  = 2'b00,
        KIND_WADDR = 2'b01,
        KIND_RADDR = 2'b10,
        KIND_WDATA = 2'b11
    } kind_e;

    // [35:34] kind, [33:32] hsize, [31:0] address or write data
    typedef struct packed {
        kind_e       kind;
        logic [1:0]  hsize;
        logic [31:0] payload;
    } entry_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WDAT = 2'd1,
        ST_ADDR = 2'd2,
        ST_DATA = 2'd3
    } state_e;

endpackage

// File: rtl/fifo_ahb_master.sv
// Pops command entries from a show-ahead FIFO and issues single non-pipelined AHB-Lite transfers.
// Latency: read with zero wait states = pop T0, NONSEQ T1, data phase T2, rsp_valid_o T3.
// Backpressure: holds the bus on hready_i=0; no pop while a transfer is outstanding or the FIFO is empty.
module fifo_ahb_master
    import fifo_ahb_master_pkg::*;
#(
    parameter int DATA_W = 36,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rempty_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic              rfifo_o,
    output logic [31:0]       haddr_o,
    output logic [1:0]        htrans_o,
    output logic              hwrite_o,
    output logic [2:0]        hsize_o,
    output logic [2:0]        hburst_o,
    output logic [3:0]        hprot_o,
    output logic [31:0]       hwdata_o,
    input  logic [31:0]       hrdata_i,
    input  logic              hready_i,
    input  logic              hresp_i,
    output logic              rsp_valid_o,
    output logic              rsp_write_o,
    output logic              rsp_err_o,
    output logic [31:0]       rsp_rdata_o,
    output logic              proto_err_o,
    output logic [CNT_W-1:0]  xfer_cnt_o,
    output logic              busy_o
);

    state_e state;
    entry_t head;

    assign head     = rdata_i;
    assign hburst_o = HBURST_SINGLE;
    assign hprot_o  = HPROT_DEF;
    assign busy_o   = (state != ST_IDLE);

    // Pop only in the cycle the head entry is consumed; WADDR/RADDR seen in WDAT stay for IDLE to reprocess
    always_comb begin
        rfifo_o = 1'b0;
        if (!rempty_i) begin
            case (state)
                ST_IDLE: rfifo_o = 1'b1;
                ST_WDAT: rfifo_o = (head.kind == KIND_WDATA) || (head.kind == KIND_RSVD);
                default: rfifo_o = 1'b0;
            endcase
        end
    end

    // Transfer sequencer: entry decode, AHB address/data phases and response capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            haddr_o     <= '0;
            htrans_o    <= HTRANS_IDLE;
            hwrite_o    <= 1'b0;
            hsize_o     <= '0;
            hwdata_o    <= '0;
            rsp_valid_o <= 1'b0;
            rsp_write_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
            proto_err_o <= 1'b0;
            xfer_cnt_o  <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rempty_i) begin
                        case (head.kind)
                            KIND_RADDR: begin
                                haddr_o  <= head.payload;
                                hsize_o  <= {1'b0, head.hsize};
                                hwrite_o <= 1'b0;
                                htrans_o <= HTRANS_NONSEQ;
                                state    <= ST_ADDR;
                            end
                            KIND_WADDR: begin
                                haddr_o  <= head.payload;
                                hsize_o  <= {1'b0, head.hsize};
                                hwrite_o <= 1'b1;
                                state    <= ST_WDAT;
                            end
                            default: proto_err_o <= 1'b1;
                        endcase
                    end
                end
                ST_WDAT: begin
                    if (!rempty_i) begin
                        case (head.kind)
                            KIND_WDATA: begin
                                hwdata_o <= head.payload;
                                htrans_o <= HTRANS_NONSEQ;
                                state    <= ST_ADDR;
                            end
                            KIND_RSVD: proto_err_o <= 1'b1;
                            default: begin
                                // Pending write is abandoned; the new command is decoded from IDLE
                                proto_err_o <= 1'b1;
                                state       <= ST_IDLE;
                            end
                        endcase
                    end
                end
                ST_ADDR: begin
                    if (hready_i) begin
                        htrans_o <= HTRANS_IDLE;
                        state    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (hready_i) begin
                        rsp_valid_o <= 1'b1;
                        rsp_write_o <= hwrite_o;
                        rsp_err_o   <= hresp_i;
                        rsp_rdata_o <= hwrite_o ? 32'h0 : hrdata_i;
                        xfer_cnt_o  <= xfer_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ahb_master.sv
// Scoreboard bench for fifo_ahb_master: FIFO model, AHB slave model and entry-stream reference model.
// Latency: checks the T0/T1/T3 read timing and cycle-accurate AHB phase behaviour.
// Backpressure: slave inserts directed and random wait states and error responses.
module tb_fifo_ahb_master;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rempty_i = 1'b1;
    logic [35:0]   rdata_i = '0;
    logic          rfifo_o;
    logic [31:0]   haddr_o;
    logic [1:0]    htrans_o;
    logic          hwrite_o;
    logic [2:0]    hsize_o;
    logic [2:0]    hburst_o;
    logic [3:0]    hprot_o;
    logic [31:0]   hwdata_o;
    logic [31:0]   hrdata_i = '0;
    logic          hready_i = 1'b1;
    logic          hresp_i = 1'b0;
    logic          rsp_valid_o;
    logic          rsp_write_o;
    logic          rsp_err_o;
    logic [31:0]   rsp_rdata_o;
    logic          proto_err_o;
    logic [CW-1:0] xfer_cnt_o;
    logic          busy_o;

    always #5 clk = ~clk;

    fifo_ahb_master #(.DATA_W(36), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .rempty_i(rempty_i), .rdata_i(rdata_i), .rfifo_o(rfifo_o),
        .haddr_o(haddr_o), .htrans_o(htrans_o), .hwrite_o(hwrite_o), .hsize_o(hsize_o),
        .hburst_o(hburst_o), .hprot_o(hprot_o), .hwdata_o(hwdata_o), .hrdata_i(hrdata_i),
        .hready_i(hready_i), .hresp_i(hresp_i), .rsp_valid_o(rsp_valid_o),
        .rsp_write_o(rsp_write_o), .rsp_err_o(rsp_err_o), .rsp_rdata_o(rsp_rdata_o),
        .proto_err_o(proto_err_o), .xfer_cnt_o(xfer_cnt_o), .busy_o(busy_o)
    );

    typedef struct {bit wr; logic [31:0] addr; logic [1:0] size; logic [31:0] wdata;} xfer_t;
    typedef struct {bit wr; bit err; logic [31:0] rdata;} rsp_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [35:0] fq[$];
    xfer_t exp_x[$];
    rsp_t  rq[$];

    // reference model state for the entry grammar
    bit          m_pend = 0;
    logic [31:0] m_pend_addr;
    logic [1:0]  m_pend_size;
    bit          m_proto = 0;
    int          m_cnt = 0;
    rsp_t        last_r;

    // slave control
    bit          rand_mode = 0;
    int          dir_aw = 0, dir_dw = 0;
    bit          dir_err = 0;
    logic [31:0] dir_rdata = 32'hDEADBEEF;
    bit          s_data = 0, s_inaddr = 0, s_err = 0;
    int          s_aw = 0, s_dw = 0;
    xfer_t       s_cur;
    bit          pop_req = 0;
    int          t_pop = 0, t_ns = 0, t_rsp = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Interpret one entry at the command-grammar level: reads, WADDR+WDATA pairs, everything else is an error
    task automatic push_entry(input logic [35:0] e);
        logic [1:0] k;
        xfer_t x;
        bit handled;
        fq.push_back(e);
        k = e[35:34];
        handled = 0;
        if (m_pend) begin
            if (k == 2'b11) begin
                x = '{wr: 1'b1, addr: m_pend_addr, size: m_pend_size, wdata: e[31:0]};
                exp_x.push_back(x);
                m_pend = 0;
                handled = 1;
            end else if (k == 2'b00) begin
                m_proto = 1;
                handled = 1;
            end else begin
                m_proto = 1;
                m_pend = 0;
            end
        end
        if (!handled) begin
            if (k == 2'b10) begin
                x = '{wr: 1'b0, addr: e[31:0], size: e[33:32], wdata: 32'h0};
                exp_x.push_back(x);
            end else if (k == 2'b01) begin
                m_pend = 1;
                m_pend_addr = e[31:0];
                m_pend_size = e[33:32];
            end else begin
                m_proto = 1;
            end
        end
    endtask

    // FIFO model: apply the pop sampled in the previous cycle, then present the new head
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_req && fq.size() > 0) fq.delete(0);
        rempty_i = (fq.size() == 0);
        rdata_i  = (fq.size() == 0) ? 36'h0 : fq[0];
    end

    // AHB slave: checks the address/data phase against the expected transfer and schedules the response
    always @(negedge clk) begin
        rsp_t r;
        if (!rst_n) begin
            s_data = 0; s_inaddr = 0; hready_i = 1'b1; hresp_i = 1'b0;
        end else begin
            hrdata_i = $urandom;
            if (s_data) begin
                chk("data_htrans", htrans_o, 2'b00);
                if (s_cur.wr) chk("data_hwdata", hwdata_o, s_cur.wdata);
                if (s_dw > 0) begin
                    hready_i = 1'b0;
                    hresp_i  = s_err && (s_dw == 1);
                    s_dw--;
                end else begin
                    hready_i = 1'b1;
                    hresp_i  = s_err;
                    if (!rand_mode) hrdata_i = dir_rdata;
                    r = '{wr: s_cur.wr, err: s_err, rdata: s_cur.wr ? 32'h0 : hrdata_i};
                    rq.push_back(r);
                    s_data = 0;
                end
            end else if (htrans_o == 2'b10) begin
                if (!s_inaddr) begin
                    s_inaddr = 1;
                    t_ns = cyc;
                    if (exp_x.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_xfer actual=NONSEQ@%0h required=no transfer", haddr_o);
                        s_cur = '{wr: hwrite_o, addr: haddr_o, size: hsize_o[1:0], wdata: hwdata_o};
                    end else begin
                        s_cur = exp_x.pop_front();
                    end
                    if (rand_mode) begin
                        s_aw  = $urandom_range(0, 2);
                        s_dw  = $urandom_range(0, 2);
                        s_err = ($urandom_range(0, 4) == 0);
                    end else begin
                        s_aw = dir_aw; s_dw = dir_dw; s_err = dir_err;
                    end
                    if (s_err && s_dw == 0) s_dw = 1;
                end
                chk("addr_haddr", haddr_o, s_cur.addr);
                chk("addr_hwrite", hwrite_o, s_cur.wr);
                chk("addr_hsize", hsize_o, {1'b0, s_cur.size});
                hresp_i = 1'b0;
                if (s_aw > 0) begin
                    hready_i = 1'b0;
                    s_aw--;
                end else begin
                    hready_i = 1'b1;
                    s_inaddr = 0;
                    s_data = 1;
                end
            end else begin
                hready_i = 1'b1;
                hresp_i  = 1'b0;
            end
        end
    end

    // Monitor: pop-legality check and response scoreboard
    always @(negedge clk) begin
        rsp_t e;
        if (!rst_n) begin
            pop_req = 0;
        end else begin
            pop_req = rfifo_o;
            if (rfifo_o) begin
                t_pop = cyc;
                chk("pop_nonempty", rempty_i, 1'b0);
            end
            if (rsp_valid_o) begin
                t_rsp = cyc;
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_rsp actual=rsp_valid required=no response (cycle %0d)", cyc);
                end else begin
                    e = rq.pop_front();
                    last_r = e;
                    chk("rsp_write", rsp_write_o, e.wr);
                    chk("rsp_err", rsp_err_o, e.err);
                    chk("rsp_rdata", rsp_rdata_o, e.rdata);
                    m_cnt++;
                    chk("xfer_cnt", xfer_cnt_o, m_cnt % (1 << CW));
                end
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (n < 3000 && !(fq.size() == 0 && rq.size() == 0 && exp_x.size() == 0 && !s_data
                                 && !s_inaddr && (!busy_o || m_pend) && !rsp_valid_o));
        if (n >= 3000) begin
            total++; bad++;
            $display("FAIL idle_timeout actual=busy required=idle within 3000 cycles");
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        fq.delete(); exp_x.delete(); rq.delete();
        m_pend = 0; m_proto = 0; m_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_htrans", htrans_o, 2'b00);
            chk("rst_busy", busy_o, 1'b0);
            chk("rst_rsp_valid", rsp_valid_o, 1'b0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        // power-on reset values
        repeat (2) @(negedge clk);
        chk("rst_outputs_a", {haddr_o, htrans_o, hwrite_o, hsize_o, hburst_o}, 64'h0);
        chk("rst_hprot", hprot_o, 4'b0011);
        chk("rst_outputs_b", {hwdata_o, rsp_valid_o, rsp_write_o, rsp_err_o, proto_err_o, busy_o, rfifo_o}, 64'h0);
        chk("rst_rsp_rdata", rsp_rdata_o, 32'h0);
        chk("rst_cnt", xfer_cnt_o, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // zero-wait read: latency and captured data
        push_entry({2'b10, 2'd2, 32'h0000_0100});
        wait_idle();
        chk("lat_nonseq", t_ns - t_pop, 1);
        chk("lat_rsp", t_rsp - t_pop, 3);
        chk("read_rdata", rsp_rdata_o, 32'hDEADBEEF);

        // write whose WDATA arrives late: master waits in WDAT without issuing
        dir_dw = 2;
        push_entry({2'b01, 2'd2, 32'h0000_0200});
        n = 0;
        while (!busy_o && n < 50) begin @(negedge clk); n++; end
        chk("wdat_entered", busy_o, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("wdat_hold", {busy_o, htrans_o}, {1'b1, 2'b00});
        end
        push_entry({2'b11, 2'd0, 32'h1234_5678});
        wait_idle();
        chk("write_rsp", {rsp_write_o, rsp_rdata_o}, {1'b1, 32'h0});

        // wait states in both phases
        dir_aw = 2; dir_dw = 2;
        push_entry({2'b10, 2'd1, 32'h0000_0208});
        wait_idle();
        chk("wait_cnt", xfer_cnt_o, 3);

        // two-cycle error response
        dir_aw = 0; dir_dw = 1; dir_err = 1;
        push_entry({2'b10, 2'd2, 32'h0000_0300});
        wait_idle();
        chk("err_rsp", rsp_err_o, 1'b1);
        chk("err_cnt", xfer_cnt_o, 4);

        // protocol violations
        dir_dw = 0; dir_err = 0;
        push_entry({2'b11, 2'd0, 32'hCAFE_0000});
        wait_idle();
        chk("proto_wdata_head", proto_err_o, 1'b1);
        chk("proto_popped", fq.size(), 0);
        push_entry({2'b01, 2'd2, 32'h0000_0400});
        push_entry({2'b10, 2'd2, 32'h0000_0500});
        wait_idle();
        chk("proto_only_read", {xfer_cnt_o, rsp_write_o}, {4'd5, 1'b0});

        // reset during the data phase abandons the transfer
        dir_dw = 6;
        push_entry({2'b10, 2'd2, 32'h0000_0600});
        n = 0;
        while (!s_data && n < 50) begin @(negedge clk); n++; end
        chk("reached_data", s_data, 1'b1);
        do_reset();
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_quiet", {rsp_valid_o, busy_o, htrans_o}, 4'h0);
        end
        chk("post_rst_cnt", {proto_err_o, xfer_cnt_o}, 0);

        // counter wrap
        dir_dw = 0;
        for (int i = 0; i < 16; i++) begin
            push_entry({2'b10, 2'd0, 32'h1000 + 32'(i * 4)});
            wait_idle();
            if (i == 14) chk("cnt_max", xfer_cnt_o, 15);
            if (i == 15) chk("cnt_wrap", xfer_cnt_o, 0);
        end

        // randomized command stream
        rand_mode = 1;
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(0, 99);
            if (n < 45) begin
                push_entry({2'b10, 2'($urandom_range(0, 3)), 32'($urandom)});
            end else if (n < 85) begin
                push_entry({2'b01, 2'($urandom_range(0, 3)), 32'($urandom)});
                repeat ($urandom_range(0, 3)) @(negedge clk);
                push_entry({2'b11, 2'($urandom_range(0, 3)), 32'($urandom)});
            end else begin
                push_entry(36'({$urandom_range(0, 15), $urandom}));
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle();
        if (m_pend) begin
            push_entry({2'b11, 2'd0, 32'($urandom)});
            wait_idle();
        end
        repeat (3) @(negedge clk);
        chk("final_proto", proto_err_o, m_proto);
        chk("final_cnt", xfer_cnt_o, m_cnt % (1 << CW));
        chk("rsp_hold", {rsp_write_o, rsp_err_o, rsp_rdata_o}, {last_r.wr, last_r.err, last_r.rdata});
        chk("final_busy", busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
